// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 panel-side receiver.
// Holds the default geometry, the colour index constants used to address the
// six shift/hold planes, the receiver state enum and the row-record payload.
package hub75_pkg;

    localparam int unsigned DEF_PANEL_WIDTH = 32;
    localparam int unsigned DEF_ADDR_W      = 5;
    localparam int unsigned DEF_CNT_W       = 6;

    // Colour index inside one half; plane index = half*3 + colour.
    localparam int unsigned R = 0;
    localparam int unsigned G = 1;
    localparam int unsigned B = 2;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RUN  = 1'b1
    } rx_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]      addr;
        logic [DEF_PANEL_WIDTH-1:0] r0;
        logic [DEF_PANEL_WIDTH-1:0] g0;
        logic [DEF_PANEL_WIDTH-1:0] b0;
        logic [DEF_PANEL_WIDTH-1:0] r1;
        logic [DEF_PANEL_WIDTH-1:0] g1;
        logic [DEF_PANEL_WIDTH-1:0] b1;
    } row_rec_t;

endpackage

// File: rtl/hub75_sync_edge.sv
// Two-flop synchroniser with optional rising-edge detection.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   d_i        : asynchronous input bus
//   q_o        : synchronised (and, with edges, optionally filtered) level
//   rise_o     : one-cycle pulse per rising edge of q_o (zero when HAS_EDGE=0)
// Build option HUB75_RX_FILTER_EN: edge-detecting instances only accept a new
// level once two consecutive samples agree, rejecting single-cycle glitches at
// the cost of one extra cycle of latency.
module hub75_sync_edge #(
    parameter int unsigned  W        = 1,
    parameter bit           HAS_EDGE = 1'b1,
    parameter logic [W-1:0] RST_VAL  = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Plain two-flop synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    if (HAS_EDGE) begin : g_edge
        logic [W-1:0] lvl;
        logic [W-1:0] prev_q;

`ifdef HUB75_RX_FILTER_EN
        logic [W-1:0] filt_q;
        logic [W-1:0] differ;

        // Adopt a level only when both synchroniser stages agree on it.
        assign differ = meta_q ^ sync_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                filt_q <= RST_VAL;
            end else begin
                filt_q <= (~differ & sync_q) | (differ & filt_q);
            end
        end

        assign lvl = filt_q;
`else
        assign lvl = sync_q;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_q <= RST_VAL;
            end else begin
                prev_q <= lvl;
            end
        end

        assign q_o    = lvl;
        assign rise_o = lvl & ~prev_q;
    end else begin : g_level
        assign q_o    = sync_q;
        assign rise_o = '0;
    end

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver: oversamples CK/LA/BL/A/RGB on clk, deserialises
// each shifted row pair and presents it on LA as a row record (valid/ready).
// Ports:
//   clk, rst_n                 : system clock, async active-low reset
//   hub_ck, hub_la, hub_bl     : HUB75 shift clock, latch, blank (async)
//   hub_addr, hub_rgb0/1       : row address and {B,G,R} for upper/lower half
//   row_valid / row_ready      : record handshake
//   row_addr, row_{r,g,b}{0,1} : record; plane MSB is the first pixel shifted
//   blank                      : synchronised hub_bl
//   width_err, overrun         : sticky error flags
// Build option HUB75_RX_FILTER_EN: glitch filter on CK/LA (see hub75_sync_edge).
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int unsigned PANEL_WIDTH = DEF_PANEL_WIDTH,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hub_ck,
    input  logic                   hub_la,
    input  logic                   hub_bl,
    input  logic [ADDR_W-1:0]      hub_addr,
    input  logic [2:0]             hub_rgb0,
    input  logic [2:0]             hub_rgb1,
    output logic                   row_valid,
    input  logic                   row_ready,
    output logic [ADDR_W-1:0]      row_addr,
    output logic [PANEL_WIDTH-1:0] row_r0,
    output logic [PANEL_WIDTH-1:0] row_g0,
    output logic [PANEL_WIDTH-1:0] row_b0,
    output logic [PANEL_WIDTH-1:0] row_r1,
    output logic [PANEL_WIDTH-1:0] row_g1,
    output logic [PANEL_WIDTH-1:0] row_b1,
    output logic                   blank,
    output logic                   width_err,
    output logic                   overrun
);

    localparam int unsigned NP = 6;
    localparam int unsigned DW = 1 + ADDR_W + NP;

    logic [1:0]    cl_rise;
    logic [1:0]    cl_lvl_unused;
    logic [DW-1:0] data_s;
    logic [DW-1:0] data_rise_unused;
    logic          ck_rise;
    logic          la_rise;
    logic [NP-1:0] rgb_s;
    logic [ADDR_W-1:0] addr_s;

    // Control strobes: {la, ck}.
    hub75_sync_edge #(
        .W       (2),
        .HAS_EDGE(1'b1),
        .RST_VAL (2'b00)
    ) u_sync_cl (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({hub_la, hub_ck}),
        .q_o   (cl_lvl_unused),
        .rise_o(cl_rise)
    );

    // Data bus: {bl, addr, rgb1, rgb0}; bl resets high so blank reads 1.
    hub75_sync_edge #(
        .W       (DW),
        .HAS_EDGE(1'b0),
        .RST_VAL ({1'b1, {(DW-1){1'b0}}})
    ) u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({hub_bl, hub_addr, hub_rgb1, hub_rgb0}),
        .q_o   (data_s),
        .rise_o(data_rise_unused)
    );

    assign ck_rise = cl_rise[0];
    assign la_rise = cl_rise[1];
    assign rgb_s   = data_s[NP-1:0];
    assign addr_s  = data_s[NP +: ADDR_W];

    rx_state_e                       state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d, cnt_post;
    logic [NP-1:0][PANEL_WIDTH-1:0]  sh_q, sh_d, shifted;
    logic [NP-1:0][PANEL_WIDTH-1:0]  hold_q, hold_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic                            valid_q, valid_d;
    logic                            werr_q, werr_d;
    logic                            ovr_q, ovr_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sh_q    <= '0;
            hold_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            werr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            werr_q  <= werr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state and datapath: shift is resolved before the latch so a
    // coincident CK/LA includes the last bit and checks the new count.
    always_comb begin
        state_d  = state_q;
        shifted  = sh_q;
        cnt_post = cnt_q;
        hold_d   = hold_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        werr_d   = werr_q;
        ovr_d    = ovr_q;

        if (state_q == RX_RUN && ck_rise) begin
            for (int unsigned p = 0; p < NP; p++) begin
                shifted[p] = {sh_q[p][PANEL_WIDTH-2:0], rgb_s[p]};
            end
            cnt_post = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end

        sh_d  = shifted;
        cnt_d = cnt_post;

        if (valid_q && row_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            RX_IDLE: begin
                // Priming latch: aligns to a row boundary, emits nothing.
                if (la_rise) begin
                    state_d = RX_RUN;
                    cnt_d   = '0;
                end
            end
            RX_RUN: begin
                if (la_rise) begin
                    hold_d  = shifted;
                    addr_d  = addr_s;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    if (cnt_post != CNT_W'(PANEL_WIDTH)) begin
                        werr_d = 1'b1;
                    end
                    if (valid_q && !row_ready) begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign row_valid = valid_q;
    assign row_addr  = addr_q;
    assign row_r0    = hold_q[R];
    assign row_g0    = hold_q[G];
    assign row_b0    = hold_q[B];
    assign row_r1    = hold_q[3 + R];
    assign row_g1    = hold_q[3 + G];
    assign row_b1    = hold_q[3 + B];
    assign blank     = data_s[DW-1];
    assign width_err = werr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Self-checking bench for hub75_rx: drives HUB75 rows with random pixel data
// and compares each emitted record against a pixel-stream model.
module tb_hub75_rx;
    import hub75_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        hub_ck, hub_la, hub_bl;
    logic [4:0]  hub_addr;
    logic [2:0]  hub_rgb0, hub_rgb1;
    logic        row_valid, row_ready;
    logic [4:0]  row_addr;
    logic [31:0] row_r0, row_g0, row_b0, row_r1, row_g1, row_b1;
    logic        blank, width_err, overrun;

    int checks = 0;
    int errors = 0;

    // Model: last 32 pixels seen per plane, pixel count, flags, pending record.
    logic [5:0][31:0] m_sh;
    int               m_cnt;
    bit               m_run, m_werr, m_ovr, m_pend;
    row_rec_t         m_exp;

    hub75_rx u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hub_ck   (hub_ck),
        .hub_la   (hub_la),
        .hub_bl   (hub_bl),
        .hub_addr (hub_addr),
        .hub_rgb0 (hub_rgb0),
        .hub_rgb1 (hub_rgb1),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .row_addr (row_addr),
        .row_r0   (row_r0),
        .row_g0   (row_g0),
        .row_b0   (row_b0),
        .row_r1   (row_r1),
        .row_g1   (row_g1),
        .row_b1   (row_b1),
        .blank    (blank),
        .width_err(width_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_rec_t dut_rec();
        row_rec_t r;
        r.addr = row_addr;
        r.r0 = row_r0; r.g0 = row_g0; r.b0 = row_b0;
        r.r1 = row_r1; r.g1 = row_g1; r.b1 = row_b1;
        return r;
    endfunction

    task automatic model_reset();
        m_sh = '0; m_cnt = 0; m_run = 0; m_werr = 0; m_ovr = 0; m_pend = 0;
        m_exp = '0;
    endtask

    task automatic model_pixel(input logic [5:0] bits);
        if (m_run) begin
            for (int p = 0; p < 6; p++) m_sh[p] = {m_sh[p][30:0], bits[p]};
            m_cnt++;
        end
    endtask

    task automatic model_latch(input logic [4:0] a);
        if (!m_run) begin
            m_run = 1;
        end else begin
            if (m_cnt != 32) m_werr = 1;
            if (m_pend) m_ovr = 1;
            m_exp.addr = a;
            m_exp.r0 = m_sh[0]; m_exp.g0 = m_sh[1]; m_exp.b0 = m_sh[2];
            m_exp.r1 = m_sh[3]; m_exp.g1 = m_sh[4]; m_exp.b1 = m_sh[5];
            m_pend = 1;
        end
        m_cnt = 0;
    endtask

    // Sends n pixels (plane MSB first) then optionally LA; called at a negedge.
    task automatic send_row(input logic [5:0][31:0] pl, input int n, input logic [4:0] a,
                            input bit simul, input bit do_la, input int glitch_at);
        logic [5:0] bits;
        hub_addr = a;
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < 6; p++) bits[p] = pl[p][31-i];
            hub_rgb0 = bits[2:0];
            hub_rgb1 = bits[5:3];
            repeat (4) @(negedge clk);
            hub_ck = 1'b1;
            model_pixel(bits);
            if (simul && do_la && i == n-1) begin
                hub_la = 1'b1;
                model_latch(a);
            end
            repeat (4) @(negedge clk);
            hub_ck = 1'b0;
            hub_la = 1'b0;
            if (i == glitch_at) begin
                repeat (4) @(negedge clk);
                hub_ck = 1'b1;
`ifndef HUB75_RX_FILTER_EN
                model_pixel(bits);
`endif
                @(negedge clk);
                hub_ck = 1'b0;
                repeat (4) @(negedge clk);
            end
        end
        if (do_la && !simul) begin
            repeat (4) @(negedge clk);
            hub_la = 1'b1;
            model_latch(a);
            repeat (4) @(negedge clk);
            hub_la = 1'b0;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic accept();
        row_ready = 1'b1;
        @(negedge clk);
        row_ready = 1'b0;
        m_pend = 0;
    endtask

    function automatic logic [5:0][31:0] rand_planes();
        logic [5:0][31:0] pl;
        for (int p = 0; p < 6; p++) pl[p] = $urandom;
        return pl;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; hub_ck = 0; hub_la = 0; hub_bl = 0; hub_addr = 0;
        hub_rgb0 = 0; hub_rgb1 = 0; row_ready = 0;
        model_reset();
        repeat (4) @(negedge clk);
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", row_valid); end
        checks++; if (width_err !== 1'b0) begin errors++; $display("FAIL reset_werr got %b exp 0", width_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun); end
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b exp 1", blank); end
        checks++; if (dut_rec() !== row_rec_t'('0)) begin errors++; $display("FAIL reset_rec got %h exp 0", dut_rec()); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [5:0][31:0] pl;
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL blank_low got %b exp 0", blank); end
        hub_bl = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL blank_high got %b exp 1", blank); end
        // Priming latch produces no record.
        send_row('0, 0, 5'd0, 0, 1, -1);
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL prime_valid got %b exp 0", row_valid); end
        pl = '0;
        pl[0] = 32'h5555_5555;
        pl[4] = 32'hFFFF_0000;
        send_row(pl, 32, 5'd3, 0, 1, -1);
        checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL row1_valid got %b exp 1", row_valid); end
        checks++; if (row_r0 !== 32'h5555_5555) begin errors++; $display("FAIL row1_r0 got %h exp 55555555", row_r0); end
        checks++; if (dut_rec() !== m_exp) begin errors++; $display("FAIL row1_rec got %h exp %h", dut_rec(), m_exp); end
        checks++; if (width_err !== 1'b0) begin errors++; $display("FAIL row1_werr got %b exp 0", width_err); end
        accept();
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL row1_drop got %b exp 0", row_valid); end
        for (int k = 0; k < 3; k++) begin
            send_row(rand_planes(), 32, 5'($urandom_range(0, 31)), 0, 1, -1);
            checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL rand_valid got %b exp 1", row_valid); end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            checks++; if (dut_rec() !== m_exp) begin errors++; $display("FAIL rand_rec got %h exp %h", dut_rec(), m_exp); end
            accept();
            checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL rand_drop got %b exp 0", row_valid); end
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_ovr got %b exp 0", overrun); end
    endtask

    task automatic test_simul();
        send_row(rand_planes(), 32, 5'd9, 1, 1, -1);
        checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL simul_valid got %b exp 1", row_valid); end
        checks++; if (dut_rec() !== m_exp) begin errors++; $display("FAIL simul_rec got %h exp %h", dut_rec(), m_exp); end
        checks++; if (width_err !== 1'b0) begin errors++; $display("FAIL simul_werr got %b exp 0", width_err); end
        accept();
    endtask

    task automatic test_back_to_back();
        send_row(rand_planes(), 32, 5'd1, 0, 1, -1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr0 got %b exp 0", overrun); end
        send_row(rand_planes(), 32, 5'd2, 0, 1, -1);
        checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL b2b_ovr got %b exp %b", overrun, m_ovr); end
        checks++; if (row_addr !== 5'd2) begin errors++; $display("FAIL b2b_addr got %0d exp 2", row_addr); end
        checks++; if (dut_rec() !== m_exp) begin errors++; $display("FAIL b2b_rec got %h exp %h", dut_rec(), m_exp); end
        accept();
        repeat (3) @(negedge clk);
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL b2b_single got %b exp 0", row_valid); end
    endtask

    task automatic test_width();
        send_row(rand_planes(), 31, 5'd7, 0, 1, -1);
        checks++; if (width_err !== 1'b1) begin errors++; $display("FAIL w31_werr got %b exp 1", width_err); end
        checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL w31_valid got %b exp 1", row_valid); end
        checks++; if (dut_rec() !== m_exp) begin errors++; $display("FAIL w31_rec got %h exp %h", dut_rec(), m_exp); end
        accept();
        send_row(rand_planes(), 32, 5'd8, 0, 1, -1);
        checks++; if (width_err !== m_werr) begin errors++; $display("FAIL w_sticky got %b exp %b", width_err, m_werr); end
        checks++; if (dut_rec() !== m_exp) begin errors++; $display("FAIL w32_rec got %h exp %h", dut_rec(), m_exp); end
        accept();
    endtask

    task automatic test_reset_mid();
        hub_bl = 1'b0;
        send_row(rand_planes(), 10, 5'd4, 0, 0, -1);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL rmid_blank got %b exp 1", blank); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_ovr got %b exp 0", overrun); end
        checks++; if (width_err !== 1'b0) begin errors++; $display("FAIL rmid_werr got %b exp 0", width_err); end
        checks++; if (dut_rec() !== row_rec_t'('0)) begin errors++; $display("FAIL rmid_rec got %h exp 0", dut_rec()); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_row(rand_planes(), 32, 5'd5, 0, 1, -1);
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL rmid_prime got %b exp 0", row_valid); end
        send_row(rand_planes(), 32, 5'd6, 0, 1, -1);
        checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid got %b exp 1", row_valid); end
        checks++; if (dut_rec() !== m_exp) begin errors++; $display("FAIL rmid_rec got %h exp %h", dut_rec(), m_exp); end
        checks++; if (width_err !== 1'b0) begin errors++; $display("FAIL rmid_werr2 got %b exp 0", width_err); end
        accept();
    endtask

    task automatic test_glitch();
        send_row(rand_planes(), 32, 5'd11, 0, 1, 15);
        checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL glitch_valid got %b exp 1", row_valid); end
        checks++; if (width_err !== m_werr) begin errors++; $display("FAIL glitch_werr got %b exp %b", width_err, m_werr); end
        checks++; if (dut_rec() !== m_exp) begin errors++; $display("FAIL glitch_rec got %h exp %h", dut_rec(), m_exp); end
        accept();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_simul();
        test_back_to_back();
        test_width();
        test_reset_mid();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
